// File: rtl/gate_vector_checker.sv
// gate_vector_checker: exhaustive operand sweep for a W-bit two-operand AND gate.
// Drives every {b,a} combination, waits SETTLE cycles, checks c_in against a & b,
// and counts mismatches in a saturating counter.
// Optional feature macro: GATE_CHK_FIRST_FAIL_EN adds first-failure capture outputs.
module gate_vector_checker #(
   parameter int unsigned W      = 3,
   parameter int unsigned SETTLE = 2,
   parameter int unsigned ERR_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [W-1:0]     c_in,
   output logic [W-1:0]     a_out,
   output logic [W-1:0]     b_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt
`ifdef GATE_CHK_FIRST_FAIL_EN
   ,
   output logic             fail_valid,
   output logic [W-1:0]     fail_a,
   output logic [W-1:0]     fail_b,
   output logic [W-1:0]     fail_c
`endif
);

   localparam int unsigned VW    = 2 * W;
   localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DRIVE  = 3'd1,
      S_SETTLE = 3'd2,
      S_CHECK  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t           state;
   state_t           state_nxt_c;
   logic [VW-1:0]    vec;
   logic [CNT_W-1:0] cnt;

   logic mismatch_c;
   logic vec_last_c;
   logic cnt_zero_c;
   logic clear_c;
   logic load_c;
   logic dec_c;
   logic err_inc_c;
   logic vec_inc_c;
   logic pass_upd_c;
   logic busy_nxt_c;
   logic done_nxt_c;

   assign mismatch_c = (c_in != (a_out & b_out));
   assign vec_last_c = &vec;
   assign cnt_zero_c = (cnt == '0);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt_c;
   end

   // Next-state logic
   always_comb begin
      state_nxt_c = state;
      case (state)
         S_IDLE:   if (start) state_nxt_c = S_DRIVE;
         S_DRIVE:  state_nxt_c = S_SETTLE;
         S_SETTLE: if (cnt_zero_c) state_nxt_c = S_CHECK;
         S_CHECK:  state_nxt_c = vec_last_c ? S_DONE : S_DRIVE;
         S_DONE:   state_nxt_c = S_IDLE;
         default:  state_nxt_c = S_IDLE;
      endcase
   end

   // Datapath strobes and next values of the registered status outputs
   always_comb begin
      clear_c    = 1'b0;
      load_c     = 1'b0;
      dec_c      = 1'b0;
      err_inc_c  = 1'b0;
      vec_inc_c  = 1'b0;
      pass_upd_c = 1'b0;
      busy_nxt_c = (state_nxt_c != S_IDLE);
      done_nxt_c = (state_nxt_c == S_DONE);
      case (state)
         S_IDLE:   clear_c = start;
         S_DRIVE:  load_c = 1'b1;
         S_SETTLE: dec_c = !cnt_zero_c;
         S_CHECK: begin
            err_inc_c = mismatch_c && (err_cnt != '1);
            vec_inc_c = !vec_last_c;
         end
         S_DONE:   pass_upd_c = 1'b1;
         default:  ;
      endcase
   end

   // Vector, operand, settle counter and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec     <= '0;
         a_out   <= '0;
         b_out   <= '0;
         cnt     <= '0;
         err_cnt <= '0;
         pass    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         busy <= busy_nxt_c;
         done <= done_nxt_c;
         if (clear_c) begin
            vec     <= '0;
            err_cnt <= '0;
            pass    <= 1'b0;
         end
         if (load_c) begin
            a_out <= vec[W-1:0];
            b_out <= vec[VW-1:W];
            cnt   <= CNT_W'(SETTLE - 1);
         end
         if (dec_c)      cnt     <= cnt - CNT_W'(1);
         if (err_inc_c)  err_cnt <= err_cnt + ERR_W'(1);
         if (vec_inc_c)  vec     <= vec + VW'(1);
         if (pass_upd_c) pass    <= (err_cnt == '0);
      end
   end

`ifdef GATE_CHK_FIRST_FAIL_EN
   // First mismatch of a sweep is latched; later ones leave it untouched
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fail_valid <= 1'b0;
         fail_a     <= '0;
         fail_b     <= '0;
         fail_c     <= '0;
      end else if (clear_c) begin
         fail_valid <= 1'b0;
         fail_a     <= '0;
         fail_b     <= '0;
         fail_c     <= '0;
      end else if ((state == S_CHECK) && mismatch_c && !fail_valid) begin
         fail_valid <= 1'b1;
         fail_a     <= a_out;
         fail_b     <= b_out;
         fail_c     <= c_in;
      end
   end
`endif

endmodule

// File: tb/tb_gate_vector_checker.sv
// Testbench for gate_vector_checker: three instances with different W/SETTLE/ERR_W,
// each wired to a behavioural gate (correct AND, stuck bit, OR, random faults).
module tb_gate_vector_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic start0, start1, start2;

   logic [2:0] c0, a0, b0;
   logic       busy0, done0, pass0;
   logic [7:0] err0;

   logic [2:0] c1, a1, b1;
   logic       busy1, done1, pass1;
   logic [3:0] err1;

   logic [0:0] c2, a2, b2;
   logic       busy2, done2, pass2;
   logic [7:0] err2;

`ifdef GATE_CHK_FIRST_FAIL_EN
   logic       fv0, fv1, fv2;
   logic [2:0] fa0, fb0, fc0, fa1, fb1, fc1;
   logic [0:0] fa2, fb2, fc2;
`endif

   int mode [3];
   int fault [3][64];
   int checks = 0;
   int errors = 0;
   int sel = 0;

   // Behaviour of the gate under test: 0 AND, 1 AND with bit0 stuck at 0, 2 OR, 3 AND xor fault mask
   function automatic int gate_ref(input int md, input int a, input int b, input int w, input int f);
      int m;
      m = (1 << w) - 1;
      case (md)
         0:       return a & b;
         1:       return (a & b) & ~1 & m;
         2:       return (a | b) & m;
         default: return ((a & b) ^ f) & m;
      endcase
   endfunction

   assign c0 = 3'(gate_ref(mode[0], int'(a0), int'(b0), 3, fault[0][int'({b0, a0})]));
   assign c1 = 3'(gate_ref(mode[1], int'(a1), int'(b1), 3, fault[1][int'({b1, a1})]));
   assign c2 = 1'(gate_ref(mode[2], int'(a2), int'(b2), 1, fault[2][int'({b2, a2})]));

   gate_vector_checker #(.W(3), .SETTLE(2), .ERR_W(8)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .c_in(c0), .a_out(a0), .b_out(b0),
      .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0)
`ifdef GATE_CHK_FIRST_FAIL_EN
      , .fail_valid(fv0), .fail_a(fa0), .fail_b(fb0), .fail_c(fc0)
`endif
   );

   gate_vector_checker #(.W(3), .SETTLE(1), .ERR_W(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .c_in(c1), .a_out(a1), .b_out(b1),
      .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1)
`ifdef GATE_CHK_FIRST_FAIL_EN
      , .fail_valid(fv1), .fail_a(fa1), .fail_b(fb1), .fail_c(fc1)
`endif
   );

   gate_vector_checker #(.W(1), .SETTLE(1), .ERR_W(8)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .c_in(c2), .a_out(a2), .b_out(b2),
      .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2)
`ifdef GATE_CHK_FIRST_FAIL_EN
      , .fail_valid(fv2), .fail_a(fa2), .fail_b(fb2), .fail_c(fc2)
`endif
   );

   // Selected instance's outputs, widened
   logic [7:0] m_a, m_b, m_err;
   logic       m_busy, m_done, m_pass;
   always_comb begin
      m_a = 8'(a0); m_b = 8'(b0); m_err = err0;
      m_busy = busy0; m_done = done0; m_pass = pass0;
      case (sel)
         1: begin
            m_a = 8'(a1); m_b = 8'(b1); m_err = 8'(err1);
            m_busy = busy1; m_done = done1; m_pass = pass1;
         end
         2: begin
            m_a = 8'(a2); m_b = 8'(b2); m_err = err2;
            m_busy = busy2; m_done = done2; m_pass = pass2;
         end
         default: ;
      endcase
   end

   function automatic int p_w(input int s); return (s == 2) ? 1 : 3; endfunction
   function automatic int p_s(input int s); return (s == 0) ? 2 : 1; endfunction
   function automatic int p_e(input int s); return (s == 1) ? 4 : 8; endfunction

   task automatic set_start(input int s, input logic v);
      case (s)
         0:       start0 = v;
         1:       start1 = v;
         default: start2 = v;
      endcase
   endtask

   // One full sweep on instance s, started from a negedge; returns at the negedge after DONE
   task automatic run_sweep(input int s, input string name, input int restart_at);
      int w, per, n, exp_done, exp_err, sat, done_k, walk_bad, first_fail, a, b, vv;
      w = p_w(s); per = p_s(s) + 2; n = 1 << (2 * w);
      exp_done = n * per + 1; sat = (1 << p_e(s)) - 1;
      exp_err = 0; first_fail = -1;
      for (int v = 0; v < n; v++) begin
         a = v & ((1 << w) - 1);
         b = v >> w;
         if (gate_ref(mode[s], a, b, w, fault[s][v]) != (a & b)) begin
            exp_err++;
            if (first_fail < 0) first_fail = v;
         end
      end
      if (exp_err > sat) exp_err = sat;
      sel = s;
      set_start(s, 1'b1);
      @(posedge clk);
      done_k = 0; walk_bad = 0;
      for (int k = 1; k <= exp_done + 20 && done_k == 0; k++) begin
         @(negedge clk);
         if (k == 1) begin
            set_start(s, 1'b0);
            checks++;
            if (m_busy !== 1'b1) begin
               errors++; $display("FAIL %s busy_rise got %0b want 1", name, m_busy);
            end
            checks++;
            if (m_err !== 8'd0 || m_pass !== 1'b0) begin
               errors++; $display("FAIL %s start_clear got err=%0d pass=%0b want 0/0", name, m_err, m_pass);
            end
         end
         if (k == restart_at) set_start(s, 1'b1);
         if (k == restart_at + 1) set_start(s, 1'b0);
         if (k >= 2) begin
            vv = (int'(m_b) << w) | int'(m_a);
            if (vv != (k - 2) / per) walk_bad++;
         end
         if (m_done === 1'b1) done_k = k;
      end
      set_start(s, 1'b0);
      checks++;
      if (done_k != exp_done) begin
         errors++; $display("FAIL %s done_cycle got %0d want %0d", name, done_k, exp_done);
      end
      checks++;
      if (walk_bad != 0) begin
         errors++; $display("FAIL %s operand_walk got %0d bad cycles want 0", name, walk_bad);
      end
      @(negedge clk);
      checks++;
      if (m_done !== 1'b0 || m_busy !== 1'b0) begin
         errors++; $display("FAIL %s after_done got done=%0b busy=%0b want 0/0", name, m_done, m_busy);
      end
      checks++;
      if (m_err !== 8'(exp_err)) begin
         errors++; $display("FAIL %s err_cnt got %0d want %0d", name, m_err, exp_err);
      end
      checks++;
      if (m_pass !== (exp_err == 0)) begin
         errors++; $display("FAIL %s pass got %0b want %0b", name, m_pass, (exp_err == 0));
      end
`ifdef GATE_CHK_FIRST_FAIL_EN
      if (s == 0) begin
         checks++;
         if (fv0 !== (first_fail >= 0)) begin
            errors++; $display("FAIL %s fail_valid got %0b want %0b", name, fv0, (first_fail >= 0));
         end
         if (first_fail >= 0) begin
            a = first_fail & 7; b = first_fail >> 3;
            checks++;
            if (fa0 !== 3'(a) || fb0 !== 3'(b) || fc0 !== 3'(gate_ref(mode[0], a, b, 3, fault[0][first_fail]))) begin
               errors++; $display("FAIL %s first_fail got a=%0d b=%0d c=%0d want a=%0d b=%0d", name, fa0, fb0, fc0, a, b);
            end
         end
      end
`endif
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({a0, b0, busy0, done0, pass0, err0} !== '0) begin
         errors++; $display("FAIL reset_dut0 got %h want 0", {a0, b0, busy0, done0, pass0, err0});
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({a2, b2, busy2, done2, pass2, err2} !== '0 || {a1, b1, busy1, done1, pass1, err1} !== '0) begin
         errors++; $display("FAIL reset_idle got %h %h want 0", {a1, b1, busy1, done1, pass1, err1}, {a2, b2, busy2, done2, pass2, err2});
      end
   endtask

   task automatic test_correct_sweep();
      mode[0] = 0;
      run_sweep(0, "and_ok", -10);
   endtask

   task automatic test_stuck_bit();
      mode[0] = 1;
      run_sweep(0, "stuck_bit0", -10);
   endtask

   task automatic test_or_gate();
      mode[0] = 2;
      run_sweep(0, "or_err8", -10);
      mode[1] = 2;
      run_sweep(1, "or_err4_sat", -10);
   endtask

   task automatic test_back_to_back();
      mode[0] = 0;
      run_sweep(0, "b2b_first", -10);
      run_sweep(0, "b2b_second", -10);
   endtask

   task automatic test_restart_ignored();
      mode[0] = 2;
      run_sweep(0, "restart_busy", 50);
   endtask

   task automatic test_reset_midsweep();
      bit saw_done, saw_busy;
      mode[0] = 1;
      sel = 0;
      start0 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start0 = 1'b0;
      repeat (99) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({a0, b0, busy0, done0, pass0, err0} !== '0) begin
         errors++; $display("FAIL midreset_outputs got %h want 0", {a0, b0, busy0, done0, pass0, err0});
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      saw_done = 1'b0; saw_busy = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (done0 === 1'b1) saw_done = 1'b1;
         if (busy0 === 1'b1) saw_busy = 1'b1;
      end
      checks++;
      if (saw_done || saw_busy) begin
         errors++; $display("FAIL midreset_quiet got done=%0b busy=%0b want 0/0", saw_done, saw_busy);
      end
      mode[0] = 0;
      run_sweep(0, "after_reset", -10);
   endtask

   task automatic test_small();
      mode[2] = 0;
      run_sweep(2, "w1_settle1", -10);
      mode[2] = 2;
      run_sweep(2, "w1_or", -10);
   endtask

   task automatic test_random_faults();
      for (int it = 0; it < 3; it++) begin
         for (int s = 0; s < 3; s++) begin
            for (int v = 0; v < 64; v++)
               fault[s][v] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
            mode[s] = 3;
            run_sweep(s, $sformatf("rand_%0d_%0d", it, s), -10);
         end
      end
   endtask

   initial begin
      test_reset();
      test_correct_sweep();
      test_stuck_bit();
      test_or_gate();
      test_back_to_back();
      test_restart_ignored();
      test_reset_midsweep();
      test_small();
      test_random_faults();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
